sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Command sequencer between a parallel host and the serial-load SRAM macro (sram_top).
- Accepts one read or write command at a time over a valid/ready handshake.
- Write: serializes the word MSB-first onto serial_in/shift, then pulses w_en.
- Read: pulses r_en, waits for data_valid, returns data_out on a one-cycle response, with timeout protection.

Parameters:
ROWS, 16, number of SRAM rows; address width AW = $clog2(ROWS)
COLS, 8, word width in bits
SHIFT_HOLD, 2, clock cycles each serial bit is held with shift=1 (>=1)
RD_TIMEOUT, 16, max cycles to wait for data_valid after r_en (>=2)

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  reset, synchronous, active-low (sampled on clk rising edge only)
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  target row
cmd_wdata  in  COLS  write data
wr_done  out  1  one-cycle pulse, write committed
rsp_valid  out  1  one-cycle pulse, read response
rsp_rdata  out  COLS  read data, valid with rsp_valid
rsp_err  out  1  read timed out, valid with rsp_valid
busy  out  1  state != IDLE
serial_in  out  1  serial data to SRAM
shift  out  1  shift strobe to SRAM
w_en  out  1  SRAM write enable
r_en  out  1  SRAM read enable
addr  out  AW  SRAM row address
data_valid  in  1  SRAM read data valid
data_out  in  COLS  SRAM read data

Behaviour:
- Reset (arst_n=0 at edge): state IDLE; all outputs 0 except cmd_ready=1; counters and latches cleared.
- Mid-operation reset aborts the operation. w_en is never asserted for a partially shifted word, and no rsp_valid/wr_done is emitted.
- All SRAM-side outputs are registered.
- addr holds the latched cmd_addr from accept until the next accept; it is 0 after reset.
- IDLE: cmd_ready=1. Accept on cmd_valid & cmd_ready at edge T, latching write, addr and wdata. Write goes to SHIFT; read goes to RD_ISSUE.
- SHIFT: cmd_ready=0 and shift=1 for exactly COLS*SHIFT_HOLD cycles, T+1 .. T+COLS*SHIFT_HOLD.
  - serial_in = wdata[COLS-1] first, stepping down one bit every SHIFT_HOLD cycles to wdata[0].
  - Then go to WRITE.
- WRITE: single cycle at T+COLS*SHIFT_HOLD+1 with w_en=1, shift=0 and wr_done=1. Then IDLE; cmd_ready=1 from T+COLS*SHIFT_HOLD+2.
  - Defaults (COLS=8, SHIFT_HOLD=2): shift for T+1..T+16, w_en at T+17.
- RD_ISSUE: r_en=1 for one cycle (T+1), then RD_WAIT with the timeout counter at 0.
- RD_WAIT: counter increments each cycle.
  - On data_valid=1: capture data_out. Next cycle rsp_valid=1, rsp_rdata=captured, rsp_err=0, then IDLE.
  - If the counter reaches RD_TIMEOUT without data_valid: next cycle rsp_valid=1, rsp_rdata=0, rsp_err=1, then IDLE.
  - data_valid and timeout in the same cycle: data wins, rsp_err=0.
- data_valid outside RD_WAIT is ignored. It never produces rsp_valid and never alters rsp_rdata.
- rsp_rdata and rsp_err hold their values after rsp_valid until the next response.
- cmd_valid while busy is not accepted. The host must hold the command, and cmd_* are ignored when cmd_ready=0.
- No back-to-back accept: at least one IDLE cycle between commands.
- w_en and r_en are never both 1. shift never coincides with w_en or r_en.

Decomposition:
- Package sram_pkg holds ROWS and COLS defaults and the state enum: IDLE, SHIFT, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
- One sub-module: sram_ser, a PISO serializer.
  - Inputs: load, word, enable.
  - Outputs: serial bit, done.
  - Contains the hold counter and the bit counter.
- The FSM, timeout counter and response registers stay in sram_ctrl.

Test Plan:
1. Reset then idle, with cmd_valid=0 for 5 cycles. Required: cmd_ready=1, busy=0, and shift, w_en, r_en, addr, rsp_valid all 0.
2. Write addr=3, wdata=8'hA5 accepted at T. Required: serial_in sequence 1,0,1,0,0,1,0,1 with each bit held 2 cycles over T+1..T+16; w_en=1 and wr_done=1 only at T+17 with addr=3; cmd_ready=1 at T+18.
3. Read addr=3 with the SRAM model returning 8'hA5 with data_valid 2 cycles after r_en. Required: r_en=1 at T+1; rsp_valid=1 at T+4 with rsp_rdata=8'hA5 and rsp_err=0.
4. Read with data_valid never asserted. Required: rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+RD_TIMEOUT+2; a stray data_valid one cycle later gives no rsp_valid.
5. arst_n=0 at T+8 during a write of 8'hFF. Required: next cycle shift=0 and cmd_ready=1; w_en and wr_done never assert; a following read of that address returns the old contents.
6. cmd_valid held high during a write for all addr 0..15 (full sweep, then read back). Required: exactly one accept per command, and every readback matches with rsp_err=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and defaults for the serial-load SRAM command sequencer.
package sram_pkg;

    localparam int SRAM_ROWS = 16;
    localparam int SRAM_COLS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_ser.sv
// MSB-first parallel-in/serial-out shifter; each bit is held
// for SHIFT_HOLD enabled cycles.
module sram_ser
    import sram_pkg::*;
#(
    parameter int COLS       = SRAM_COLS,
    parameter int SHIFT_HOLD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [COLS-1:0] word,
    input  logic            enable,
    output logic            bit_out,
    output logic            done
);

    localparam int HW = cnt_w(SHIFT_HOLD);
    localparam int BW = cnt_w(COLS);

    logic [COLS-1:0] sreg;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            hold_end;

    assign hold_end = (hold_cnt == HW'(SHIFT_HOLD - 1));
    assign bit_out  = sreg[COLS-1];
    // High during the last held cycle of the last bit.
    assign done     = enable && hold_end && (bit_cnt == BW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg     <= '0;
            hold_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            sreg     <= word;
            hold_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (hold_end) begin
                hold_cnt <= '0;
                sreg     <= {sreg[COLS-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Host command sequencer for the serial-load SRAM macro: shifts write
// words in, pulses w_en/r_en and returns read responses with timeout.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS       = SRAM_ROWS,
    parameter int COLS       = SRAM_COLS,
    parameter int SHIFT_HOLD = 2,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [$clog2(ROWS)-1:0] cmd_addr,
    input  logic [COLS-1:0]         cmd_wdata,
    output logic                    wr_done,
    output logic                    rsp_valid,
    output logic [COLS-1:0]         rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    serial_in,
    output logic                    shift,
    output logic                    w_en,
    output logic                    r_en,
    output logic [$clog2(ROWS)-1:0] addr,
    input  logic                    data_valid,
    input  logic [COLS-1:0]         data_out
);

    localparam int TW = cnt_w(RD_TIMEOUT);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          ser_load;
    logic          ser_en;
    logic          ser_done;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ser_load  = (state == IDLE) && cmd_valid && cmd_write;
    assign ser_en    = (state == SHIFT);

    sram_ser #(
        .COLS       (COLS),
        .SHIFT_HOLD (SHIFT_HOLD)
    ) u_ser (
        .clk     (clk),
        .rst_n   (arst_n),
        .load    (ser_load),
        .word    (cmd_wdata),
        .enable  (ser_en),
        .bit_out (serial_in),
        .done    (ser_done)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= IDLE;
            addr      <= '0;
            shift     <= 1'b0;
            w_en      <= 1'b0;
            r_en      <= 1'b0;
            wr_done   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            w_en      <= 1'b0;
            r_en      <= 1'b0;
            wr_done   <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr <= cmd_addr;
                        if (cmd_write) begin
                            state <= SHIFT;
                            shift <= 1'b1;
                        end else begin
                            state <= RD_ISSUE;
                            r_en  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (ser_done) begin
                        state   <= WRITE;
                        shift   <= 1'b0;
                        w_en    <= 1'b1;
                        wr_done <= 1'b1;
                    end
                end
                WRITE: state <= IDLE;
                RD_ISSUE: begin
                    state   <= RD_WAIT;
                    tmo_cnt <= '0;
                end
                RD_WAIT: begin
                    // Data arriving on the final wait cycle beats the timeout.
                    if (data_valid) begin
                        state     <= RD_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= data_out;
                        rsp_err   <= 1'b0;
                    end else if (tmo_cnt == TW'(RD_TIMEOUT - 1)) begin
                        state     <= RD_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RD_RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM responder model, response scoreboard,
// vector table and hand-written timing sequences.
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int HOLD = 2;
    localparam int TMO  = 16;
    localparam int AW   = 4;

    logic            clk;
    logic            arst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [COLS-1:0] cmd_wdata;
    logic            wr_done;
    logic            rsp_valid;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic            serial_in;
    logic            shift;
    logic            w_en;
    logic            r_en;
    logic [AW-1:0]   addr;
    logic            data_valid;
    logic [COLS-1:0] data_out;

    sram_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SHIFT_HOLD (HOLD),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .wr_done    (wr_done),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .serial_in  (serial_in),
        .shift      (shift),
        .w_en       (w_en),
        .r_en       (r_en),
        .addr       (addr),
        .data_valid (data_valid),
        .data_out   (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // SRAM responder: shifts in one bit per HOLD cycles, answers r_en
    // with data_valid rd_delay cycles later (0 = never answer).
    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] sr = '0;
    int              ph = 0;
    int              rd_delay = 2;
    int              dv_cnt = 0;
    logic [AW-1:0]   rd_a = '0;
    logic            m_dv = 1'b0;
    logic [COLS-1:0] m_do = '0;
    logic            f_dv = 1'b0;
    logic [COLS-1:0] f_do = '0;

    assign data_valid = m_dv | f_dv;
    assign data_out   = f_dv ? f_do : m_do;

    initial for (int i = 0; i < ROWS; i++) mem[i] = '0;

    always @(posedge clk) begin
        m_dv <= 1'b0;
        if (shift) begin
            if (ph == HOLD - 1) begin
                sr <= {sr[COLS-2:0], serial_in};
                ph <= 0;
            end else begin
                ph <= ph + 1;
            end
        end else begin
            ph <= 0;
        end
        if (w_en) mem[addr] <= sr;
        if (r_en) begin
            rd_a <= addr;
            if (rd_delay == 1) begin
                m_dv <= 1'b1;
                m_do <= mem[addr];
            end else if (rd_delay > 1) begin
                dv_cnt <= rd_delay - 1;
            end
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                m_dv <= 1'b1;
                m_do <= mem[rd_a];
            end
        end
    end

    typedef struct {
        logic            wr;
        logic [AW-1:0]   a;
        logic [COLS-1:0] d;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (arst_n) begin
            if (cmd_valid && cmd_ready) accepts++;
            chk("strobe_overlap",
                32'((w_en & r_en) | (shift & (w_en | r_en))), 0);
            if (wr_done) begin
                if (sb.size() == 0) begin
                    chk("wr_done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_kind", 32'(e.wr), 1);
                    chk("wr_addr", 32'(addr), 32'(e.a));
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_kind", 32'(e.wr), 0);
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [COLS-1:0] d, output int t);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        t = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr_done || rsp_valid) && n < 200);
        if (!(wr_done || rsp_valid)) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic            wr;
        logic [AW-1:0]   a;
        logic [COLS-1:0] d;
        int              dly;
        logic [COLS-1:0] exp_d;
        logic            exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int lat;
        logic [COLS-1:0] wd;
        logic [COLS-1:0] p;
        logic [3:0] a4;
        int base;

        tbl[0] = '{1'b1, 4'd1,  8'h00, 2,       8'h00, 1'b0};
        tbl[1] = '{1'b1, 4'd2,  8'hFF, 2,       8'hFF, 1'b0};
        tbl[2] = '{1'b1, 4'd15, 8'h81, 2,       8'h81, 1'b0};
        tbl[3] = '{1'b0, 4'd1,  8'h00, 1,       8'h00, 1'b0};
        tbl[4] = '{1'b0, 4'd2,  8'h00, 2,       8'hFF, 1'b0};
        tbl[5] = '{1'b0, 4'd15, 8'h00, TMO,     8'h81, 1'b0};
        tbl[6] = '{1'b0, 4'd2,  8'h00, TMO + 1, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 4'd15, 8'h00, 5,       8'h81, 1'b0};
        tbl[8] = '{1'b1, 4'd0,  8'h3C, 2,       8'h3C, 1'b0};
        tbl[9] = '{1'b0, 4'd0,  8'h00, 3,       8'h3C, 1'b0};

        arst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_outs", 32'({busy, shift, w_en, r_en, rsp_valid,
                             wr_done, serial_in}), 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_ready", 32'(cmd_ready), 1);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_strobes", 32'({shift, w_en, r_en, rsp_valid}), 0);
            chk("idle_addr", 32'(addr), 0);
        end

        // Write A5 to row 3: serial pattern and commit timing
        wd = 8'hA5;
        sb.push_back(exp_t'{1'b1, 4'd3, 8'hA5, 1'b0});
        send(1'b1, 4'd3, wd, t);
        for (int k = 1; k <= COLS * HOLD; k++) begin
            @(negedge clk);
            chk("wr_shift", 32'(shift), 1);
            chk("wr_serial", 32'(serial_in),
                32'(wd[COLS - 1 - (k - 1) / HOLD]));
            chk("wr_wen_early", 32'(w_en), 0);
            chk("wr_ready_busy", 32'(cmd_ready), 0);
        end
        @(negedge clk);
        chk("wr_wen", 32'(w_en), 1);
        chk("wr_done", 32'(wr_done), 1);
        chk("wr_addr3", 32'(addr), 3);
        chk("wr_shift_off", 32'(shift), 0);
        @(negedge clk);
        chk("wr_ready_after", 32'(cmd_ready), 1);

        // Read row 3 with data_valid 2 cycles after r_en
        rd_delay = 2;
        sb.push_back(exp_t'{1'b0, 4'd3, 8'hA5, 1'b0});
        send(1'b0, 4'd3, 8'h00, t);
        @(negedge clk);
        chk("rd_ren", 32'(r_en), 1);
        chk("rd_addr", 32'(addr), 3);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            chk("rd_rsp_early", 32'(rsp_valid), 0);
        end
        @(negedge clk);
        chk("rd_rsp_valid", 32'(rsp_valid), 1);
        chk("rd_rsp_data", 32'(rsp_rdata), 32'hA5);
        chk("rd_rsp_err", 32'(rsp_err), 0);
        @(negedge clk);
        chk("rd_ready_after", 32'(cmd_ready), 1);

        // Read timeout, then a stray data_valid in IDLE
        rd_delay = 0;
        sb.push_back(exp_t'{1'b0, 4'd5, 8'h00, 1'b1});
        send(1'b0, 4'd5, 8'h00, t);
        for (int k = 1; k <= TMO + 2; k++) begin
            @(negedge clk);
            chk("tmo_rsp_time", 32'(rsp_valid), 32'(k == TMO + 2));
        end
        chk("tmo_err", 32'(rsp_err), 1);
        chk("tmo_rdata", 32'(rsp_rdata), 0);
        @(posedge clk);
        #1;
        f_dv = 1'b1;
        f_do = 8'h3C;
        @(posedge clk);
        #1;
        f_dv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_rsp", 32'(rsp_valid), 0);
            chk("stray_rdata", 32'(rsp_rdata), 0);
            chk("stray_err", 32'(rsp_err), 1);
        end
        rd_delay = 2;

        // Reset in the middle of shifting FF over row 7 (holds 5A)
        sb.push_back(exp_t'{1'b1, 4'd7, 8'h5A, 1'b0});
        send(1'b1, 4'd7, 8'h5A, t);
        wait_done();
        send(1'b1, 4'd7, 8'hFF, t);
        repeat (7) @(posedge clk);
        #1;
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("abort_shift", 32'(shift), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("abort_no_write", 32'({w_en, wr_done}), 0);
        end
        sb.push_back(exp_t'{1'b0, 4'd7, 8'h5A, 1'b0});
        send(1'b0, 4'd7, 8'h00, t);
        wait_done();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            rd_delay = tbl[i].dly;
            sb.push_back(exp_t'{tbl[i].wr, tbl[i].a, tbl[i].exp_d,
                                tbl[i].exp_err});
            send(tbl[i].wr, tbl[i].a, tbl[i].d, t);
            wait_done();
            if (tbl[i].wr) lat = COLS * HOLD + 1;
            else if (tbl[i].dly >= 1 && tbl[i].dly <= TMO)
                lat = tbl[i].dly + 2;
            else lat = TMO + 2;
            chk("tbl_latency", 32'(cyc - t), 32'(lat));
        end
        rd_delay = 2;

        // Full sweep with cmd_valid held through each write
        base = accepts;
        for (int a = 0; a < ROWS; a++) begin
            int n;
            a4 = 4'(a);
            p  = {a4, ~a4};
            sb.push_back(exp_t'{1'b1, a4, p, 1'b0});
            @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = a4;
            cmd_wdata = p;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wr_done && n < 100);
            if (!wr_done) chk("sweep_timeout", 0, 1);
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk("sweep_accepts", 32'(accepts - base), 32'(ROWS));
        for (int a = 0; a < ROWS; a++) begin
            a4 = 4'(a);
            p  = {a4, ~a4};
            sb.push_back(exp_t'{1'b0, a4, p, 1'b0});
            send(1'b0, a4, 8'h00, t);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
